track_loader: RTL and testbench

TRACK_LOADER -- requirements
Module: track_loader

---
 rtl/track_loader_pkg.sv | 20 ++
 rtl/track_loader_if.sv | 24 ++
 rtl/track_loader_bram.sv | 32 +++
 rtl/track_loader.sv | 189 ++++++++++++++++++
 tb/tb_track_loader.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/track_loader_pkg.sv
// Shared constants, state encoding and LBA helper for the floppy track loader.
package track_loader_pkg;

  localparam int SECTORS_PER_TRACK = 13;
  localparam int SECTOR_BYTES      = 512;
  localparam int TRACK_BYTES       = SECTORS_PER_TRACK * SECTOR_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_START_READ = 2'd2,
    ST_READ       = 2'd3
  } state_t;

  // First SD sector of a track: unsigned product, zero-extended to 32 bits.
  function automatic logic [31:0] track_lba(input logic [31:0] spt, input logic [5:0] trk);
    return spt * {26'd0, trk};
  endfunction

endpackage

// File: rtl/track_loader_if.sv
// SD-host sector transfer bus between the track loader (master) and the host (slave).
interface track_loader_if;
  import track_loader_pkg::*;

  logic [31:0]                      lba_fdd;
  logic                             sd_rd;
  logic                             sd_wr;
  logic                             sd_ack;
  logic [$clog2(SECTOR_BYTES)-1:0]  sd_buff_addr;
  logic                             sd_buff_wr;
  logic [7:0]                       sd_buff_dout;
  logic [7:0]                       sd_buff_din;

  modport master (
    output lba_fdd, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout
  );

  modport slave (
    input  lba_fdd, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout
  );

endinterface

// File: rtl/track_loader_bram.sv
// Single-clock true dual-port RAM with registered read data on both ports.
// Contents are never reset; on a same-address double write port B wins.
module bram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic              we_a_i,
  input  logic [DATA_W-1:0] d_a_i,
  output logic [DATA_W-1:0] q_a_o,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic              we_b_i,
  input  logic [DATA_W-1:0] d_b_i,
  output logic [DATA_W-1:0] q_b_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  // Memory writes from both ports and registered (read-first) read data.
  always_ff @(posedge clk) begin
    if (we_a_i) begin
      mem_q[addr_a_i] <= d_a_i;
    end
    if (we_b_i) begin
      mem_q[addr_b_i] <= d_b_i;
    end
    q_a_o <= mem_q[addr_a_i];
    q_b_o <= mem_q[addr_b_i];
  end

endmodule

// File: rtl/track_loader.sv
// Floppy track loader: keeps one track in a dual-port buffer, writes it back to
// the SD image when the drive has modified it, then reads the requested track.
module track_loader
  import track_loader_pkg::*;
#(
  parameter int SECTORS = 13,
  parameter int BUF_AW  = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         track,
  input  logic               img_mounted,
  input  logic [63:0]        img_size,
  track_loader_if.master     sd,
  input  logic [BUF_AW-1:0]  fd_track_addr,
  input  logic               fd_write_disk,
  input  logic [7:0]         fd_data_do,
  output logic [7:0]         fd_data_in,
  output logic               cpu_wait_fdd
);

  localparam logic [31:0] SPT      = 32'(SECTORS);
  localparam logic [3:0]  LAST_SEC = 4'(SECTORS - 1);

  state_t      state_q,     state_d;
  logic [3:0]  track_sec_q, track_sec_d;
  logic [31:0] lba_q,       lba_d;
  logic        sd_rd_q,     sd_rd_d;
  logic        sd_wr_q,     sd_wr_d;
  logic        wait_q,      wait_d;
  logic        dirty_q,     dirty_d;
  logic        mounted_q,   mounted_d;
  logic [5:0]  cur_track_q, cur_track_d;
  logic        old_ack_q;

  logic        rise_s;
  logic        fall_s;
  logic        trigger_s;

  assign rise_s    = ~old_ack_q & sd.sd_ack;
  assign fall_s    =  old_ack_q & ~sd.sd_ack;
  assign trigger_s = (cur_track_q != track) | (mounted_q & ~img_mounted);

  assign sd.lba_fdd    = lba_q;
  assign sd.sd_rd      = sd_rd_q;
  assign sd.sd_wr      = sd_wr_q;
  assign cpu_wait_fdd  = wait_q;

  // Next-state and transfer bookkeeping for the load/write-back sequencer.
  always_comb begin
    state_d     = state_q;
    track_sec_d = track_sec_q;
    lba_d       = lba_q;
    sd_rd_d     = sd_rd_q;
    sd_wr_d     = sd_wr_q;
    wait_d      = wait_q;
    dirty_d     = dirty_q;
    mounted_d   = mounted_q | img_mounted;
    cur_track_d = cur_track_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          mounted_d = 1'b0;
          if (img_size == 64'd0) begin
            state_d = ST_IDLE;
          end else if (dirty_q) begin
            // Flush the modified buffer to the track it was loaded from.
            track_sec_d = 4'd0;
            lba_d       = track_lba(SPT, cur_track_q);
            sd_wr_d     = 1'b1;
            wait_d      = 1'b1;
            dirty_d     = 1'b0;
            state_d     = ST_WRITE;
          end else begin
            state_d = ST_START_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (rise_s) begin
          lba_d = lba_q + 32'd1;
          if (track_sec_q >= LAST_SEC) begin
            sd_wr_d = 1'b0;
          end else begin
            sd_wr_d = sd_wr_q;
          end
        end else if (fall_s) begin
          track_sec_d = track_sec_q + 4'd1;
          if (!sd_wr_q) begin
            state_d = ST_START_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_START_READ: begin
        // Track is latched only here, so mid-transfer changes wait for IDLE.
        cur_track_d = track;
        track_sec_d = 4'd0;
        lba_d       = track_lba(SPT, track);
        sd_rd_d     = 1'b1;
        wait_d      = 1'b1;
        state_d     = ST_READ;
      end

      ST_READ: begin
        if (rise_s) begin
          lba_d = lba_q + 32'd1;
          if (track_sec_q >= LAST_SEC) begin
            sd_rd_d = 1'b0;
          end else begin
            sd_rd_d = sd_rd_q;
          end
        end else if (fall_s) begin
          track_sec_d = track_sec_q + 4'd1;
          if (!sd_rd_q) begin
            wait_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_READ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A drive write in the same cycle as a write-back launch keeps the buffer dirty.
    if (fd_write_disk) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_d;
    end
  end

  // Sequencer registers with synchronous reset; aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      track_sec_q <= 4'd0;
      lba_q       <= 32'd0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      wait_q      <= 1'b0;
      dirty_q     <= 1'b0;
      mounted_q   <= 1'b0;
      cur_track_q <= 6'd0;
      old_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      track_sec_q <= track_sec_d;
      lba_q       <= lba_d;
      sd_rd_q     <= sd_rd_d;
      sd_wr_q     <= sd_wr_d;
      wait_q      <= wait_d;
      dirty_q     <= dirty_d;
      mounted_q   <= mounted_d;
      cur_track_q <= cur_track_d;
      old_ack_q   <= sd.sd_ack;
    end
  end

  bram #(
    .DATA_W (8),
    .ADDR_W (BUF_AW)
  ) u_buf (
    .clk      (clk),
    .addr_a_i ({1'b0, track_sec_q, sd.sd_buff_addr}),
    .we_a_i   (sd.sd_buff_wr & sd.sd_ack),
    .d_a_i    (sd.sd_buff_dout),
    .q_a_o    (sd.sd_buff_din),
    .addr_b_i (fd_track_addr),
    .we_b_i   (fd_write_disk),
    .d_b_i    (fd_data_do),
    .q_b_o    (fd_data_in)
  );

endmodule

// File: tb/tb_track_loader.sv
// Directed bench for track_loader: an SD-host model serves sector requests and
// compares each against a queue of expected (direction, LBA) pairs.
module tb_track_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        img_mounted;
  logic [63:0] img_size;
  logic [13:0] fd_track_addr;
  logic        fd_write_disk;
  logic [7:0]  fd_data_do;
  logic [7:0]  fd_data_in;
  logic        cpu_wait_fdd;

  track_loader_if sd_bus ();

  track_loader dut (
    .clk           (clk),
    .reset         (reset),
    .track         (track),
    .img_mounted   (img_mounted),
    .img_size      (img_size),
    .sd            (sd_bus),
    .fd_track_addr (fd_track_addr),
    .fd_write_disk (fd_write_disk),
    .fd_data_do    (fd_data_do),
    .fd_data_in    (fd_data_in),
    .cpu_wait_fdd  (cpu_wait_fdd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] lba;
  } req_t;

  req_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [63:0] DISK_SIZE = 64'd143360;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic void push_load(input logic wr, input int t);
    req_t r;
    for (int k = 0; k < 13; k++) begin
      r.wr  = wr;
      r.lba = 32'(13 * t + k);
      exp_q.push_back(r);
    end
  endfunction

  // Host model: serve n sector requests; on reads it also writes byte 0x3A+sector at offset 7.
  task automatic serve(input int n);
    int   waited;
    int   k;
    req_t e;
    for (int s = 0; s < n; s++) begin
      waited = 0;
      while (!(sd_bus.sd_rd | sd_bus.sd_wr) && waited < 12) begin
        @(negedge clk);
        waited++;
      end
      if (!(sd_bus.sd_rd | sd_bus.sd_wr)) begin
        check("req_timeout", 64'd0, 64'd1);
        return;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_req", 64'd1, 64'd0);
        return;
      end
      e = exp_q.pop_front();
      check("req_is_wr", 64'(sd_bus.sd_wr), 64'(e.wr));
      check("req_rd_wr_excl", 64'(sd_bus.sd_rd & sd_bus.sd_wr), 64'd0);
      check("req_lba", 64'(sd_bus.lba_fdd), 64'(e.lba));
      check("cpu_wait_busy", 64'(cpu_wait_fdd), 64'd1);
      k = int'(e.lba % 32'd13);
      sd_bus.sd_ack       = 1'b1;
      sd_bus.sd_buff_addr = 9'd7;
      sd_bus.sd_buff_dout = 8'h3A + 8'(k);
      sd_bus.sd_buff_wr   = ~e.wr;
      @(negedge clk);
      sd_bus.sd_buff_wr   = 1'b0;
      @(negedge clk);
      sd_bus.sd_ack       = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wait"}, 64'(cpu_wait_fdd), 64'd0);
    check({tag, "_rd"},   64'(sd_bus.sd_rd), 64'd0);
    check({tag, "_wr"},   64'(sd_bus.sd_wr), 64'd0);
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fd_read_check(input string tag, input logic [13:0] addr, input logic [7:0] expv);
    fd_track_addr = addr;
    @(negedge clk);
    check(tag, 64'(fd_data_in), 64'(expv));
  endtask

  initial begin
    reset               = 1'b1;
    track               = 6'd0;
    img_mounted         = 1'b0;
    img_size            = 64'd0;
    fd_track_addr       = 14'd0;
    fd_write_disk       = 1'b0;
    fd_data_do          = 8'd0;
    sd_bus.sd_ack       = 1'b0;
    sd_bus.sd_buff_addr = 9'd0;
    sd_bus.sd_buff_wr   = 1'b0;
    sd_bus.sd_buff_dout = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_lba",  64'(sd_bus.lba_fdd), 64'd0);
    check("rst_rd",   64'(sd_bus.sd_rd),   64'd0);
    check("rst_wr",   64'(sd_bus.sd_wr),   64'd0);
    check("rst_wait", 64'(cpu_wait_fdd),   64'd0);
    reset    = 1'b0;
    img_size = DISK_SIZE;
    repeat (3) @(negedge clk);
    check_idle("premount");

    // Mount track 0: reads LBA 0..12
    push_load(1'b0, 0);
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
    serve(13);
    check_idle("mount_done");

    // Clean track change 0 -> 5: reads only, from LBA 65
    push_load(1'b0, 5);
    track = 6'd5;
    serve(13);
    check_idle("trk5_done");

    // SD-written bytes visible on the drive port
    fd_read_check("rt_sec2_off7",  14'h0407, 8'h3C);
    fd_read_check("rt_sec0_off7",  14'h0007, 8'h3A);
    fd_read_check("rt_sec12_off7", 14'h1807, 8'h46);

    // Dirty write-back: load 3, drive write, then 4
    push_load(1'b0, 3);
    track = 6'd3;
    serve(13);
    check_idle("trk3_done");
    fd_track_addr = 14'h0100;
    fd_data_do    = 8'hA5;
    fd_write_disk = 1'b1;
    @(negedge clk);
    fd_write_disk = 1'b0;
    @(negedge clk);
    check_idle("after_fd_write");
    push_load(1'b1, 3);
    push_load(1'b0, 4);
    track = 6'd4;
    @(negedge clk);
    check("wb_first_wr", 64'(sd_bus.sd_wr), 64'd1);
    sd_bus.sd_buff_addr = 9'h100;
    @(negedge clk);
    check("wb_buff_din", 64'(sd_bus.sd_buff_din), 64'hA5);
    serve(26);
    check_idle("trk4_done");

    // No disk: track change must not start anything
    img_size = 64'd0;
    track    = 6'd6;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("nodisk_quiet", 64'({sd_bus.sd_rd, sd_bus.sd_wr, cpu_wait_fdd}), 64'd0);
    end

    // Reset mid-READ after sector 5, then reload track 34 from LBA 442
    push_load(1'b0, 7);
    track    = 6'd7;
    img_size = DISK_SIZE;
    serve(6);
    reset = 1'b1;
    track = 6'd34;
    @(negedge clk);
    check("midrst_lba",  64'(sd_bus.lba_fdd), 64'd0);
    check("midrst_rd",   64'(sd_bus.sd_rd),   64'd0);
    check("midrst_wr",   64'(sd_bus.sd_wr),   64'd0);
    check("midrst_wait", 64'(cpu_wait_fdd),   64'd0);
    exp_q.delete();
    reset = 1'b0;
    fd_read_check("buf_kept_0100", 14'h0100, 8'hA5);
    push_load(1'b0, 34);
    serve(13);
    check_idle("trk34_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
